// File: rtl/branch_redirect_ctrl.sv
// EX-stage control-flow redirect sequencer: PC redirect handshake to fetch, IF/ID flush, EX stall.
// Optional statistics counters enabled by BRANCH_REDIRECT_STATS_EN.
module branch_redirect_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ex_valid,
  input  logic             i_ex_is_branch,
  input  logic             i_ex_is_jump,
  input  logic             i_branch_taken,
  input  logic [XLEN-1:0]  i_target_pc,
  input  logic             i_fetch_ready,
  output logic             o_redirect_valid,
  output logic [XLEN-1:0]  o_redirect_pc,
  output logic             o_flush_if,
  output logic             o_flush_id,
  output logic             o_stall_ex,
  output logic             o_misaligned,
  output logic [CNT_W-1:0] o_br_count,
  output logic [CNT_W-1:0] o_taken_count,
  output logic [CNT_W-1:0] o_stall_cycles
);

  localparam int unsigned BUB_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  state_e            state_q, state_n;
  logic [BUB_W-1:0]  bub_q, bub_n;
  logic [XLEN-1:0]   pc_q, pc_n;
  logic              valid_q, valid_n;
  logic              stall_q, stall_n;
  logic              mis_q, mis_n;
  logic              take_c;
  logic              aligned_c;

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_n   = state_q;
    bub_n     = bub_q;
    pc_n      = pc_q;
    mis_n     = 1'b0;
    take_c    = i_ex_valid & (i_ex_is_jump | (i_ex_is_branch & i_branch_taken));
    aligned_c = (i_target_pc[1:0] == 2'b00);
    case (state_q)
      IDLE: begin
        if (take_c) begin
          if (aligned_c) begin
            pc_n    = i_target_pc;
            state_n = REDIRECT;
          end else begin
            mis_n = 1'b1;
          end
        end
      end
      REDIRECT: begin
        if (i_fetch_ready) begin
          bub_n   = BUB_W'(FLUSH_CYCLES - 1);
          state_n = FLUSH;
        end
      end
      FLUSH: begin
        if (bub_q == '0) begin
          state_n = IDLE;
        end else begin
          bub_n = bub_q - BUB_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    valid_n = (state_n == REDIRECT);
    stall_n = (state_n != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      bub_q   <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      stall_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      bub_q   <= bub_n;
      pc_q    <= pc_n;
      valid_q <= valid_n;
      stall_q <= stall_n;
      mis_q   <= mis_n;
    end
  end

  assign o_redirect_valid = valid_q;
  assign o_redirect_pc    = pc_q;
  assign o_flush_if       = stall_q;
  assign o_flush_id       = stall_q;
  assign o_stall_ex       = stall_q;
  assign o_misaligned     = mis_q;

`ifdef BRANCH_REDIRECT_STATS_EN
  logic [CNT_W-1:0] br_cnt_q, tk_cnt_q, st_cnt_q;
  logic             br_ev_c, tk_ev_c;

  assign br_ev_c = (state_q == IDLE) & i_ex_valid & (i_ex_is_branch | i_ex_is_jump);
  assign tk_ev_c = (state_q == IDLE) & take_c;

  // Saturating event counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      if (br_ev_c && (br_cnt_q != '1)) br_cnt_q <= br_cnt_q + CNT_W'(1);
      if (tk_ev_c && (tk_cnt_q != '1)) tk_cnt_q <= tk_cnt_q + CNT_W'(1);
      if (stall_q && (st_cnt_q != '1)) st_cnt_q <= st_cnt_q + CNT_W'(1);
    end
  end

  assign o_br_count     = br_cnt_q;
  assign o_taken_count  = tk_cnt_q;
  assign o_stall_cycles = st_cnt_q;
`else
  assign o_br_count     = '0;
  assign o_taken_count  = '0;
  assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: stimulus pushes expectations, a negedge monitor checks them.
module tb_branch_redirect_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 32;

  localparam int K_MARK    = 0;
  localparam int K_VALID   = 1;
  localparam int K_STALL   = 2;
  localparam int K_MIS     = 3;
  localparam int K_ZERO    = 4;
  localparam int K_MIS_NOW = 5;
  localparam int K_BR      = 6;
  localparam int K_TK      = 7;
  localparam int K_ST      = 8;
  localparam int K_SAT     = 9;
  localparam int K_END     = 10;

  typedef struct {
    int     kind;
    string  name;
    longint exp;
  } req_t;

  logic             i_clk, i_rst_n;
  logic             i_ex_valid, i_ex_is_branch, i_ex_is_jump, i_branch_taken;
  logic [XLEN-1:0]  i_target_pc;
  logic             i_fetch_ready;
  logic             o_redirect_valid;
  logic [XLEN-1:0]  o_redirect_pc;
  logic             o_flush_if, o_flush_id, o_stall_ex, o_misaligned;
  logic [CNT_W-1:0] o_br_count, o_taken_count, o_stall_cycles;

  req_t             req_q[$];
  logic [XLEN-1:0]  redir_q[$];
  int               mis_q[$];

  int tests = 0;
  int fails = 0;

  branch_redirect_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_ex_valid(i_ex_valid), .i_ex_is_branch(i_ex_is_branch), .i_ex_is_jump(i_ex_is_jump),
    .i_branch_taken(i_branch_taken), .i_target_pc(i_target_pc), .i_fetch_ready(i_fetch_ready),
    .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
    .o_flush_if(o_flush_if), .o_flush_id(o_flush_id), .o_stall_ex(o_stall_ex),
    .o_misaligned(o_misaligned),
    .o_br_count(o_br_count), .o_taken_count(o_taken_count), .o_stall_cycles(o_stall_cycles)
  );

`ifdef BRANCH_REDIRECT_STATS_EN
  logic             s_valid, s_fi, s_fd, s_stall, s_mis;
  logic [XLEN-1:0]  s_pc;
  logic [3:0]       s_br, s_tk, s_st;

  branch_redirect_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(2), .CNT_W(4)) dut_sat (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_ex_valid(i_ex_valid), .i_ex_is_branch(i_ex_is_branch), .i_ex_is_jump(i_ex_is_jump),
    .i_branch_taken(i_branch_taken), .i_target_pc(i_target_pc), .i_fetch_ready(i_fetch_ready),
    .o_redirect_valid(s_valid), .o_redirect_pc(s_pc),
    .o_flush_if(s_fi), .o_flush_id(s_fd), .o_stall_ex(s_stall), .o_misaligned(s_mis),
    .o_br_count(s_br), .o_taken_count(s_tk), .o_stall_cycles(s_st)
  );
`endif

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Monitor: sole owner of tests/fails and of the per-phase event counters.
  initial begin
    int              cnt_stall, cnt_valid, cnt_mis;
    logic            prev_valid;
    logic [XLEN-1:0] prev_pc, exp_pc;
    req_t            r;
    cnt_stall  = 0;
    cnt_valid  = 0;
    cnt_mis    = 0;
    prev_valid = 1'b0;
    prev_pc    = '0;
    forever begin
      @(negedge i_clk);
      if (o_stall_ex) cnt_stall++;
      if (o_redirect_valid) cnt_valid++;
      if (o_misaligned) cnt_mis++;
      check("flush_if_tracks_stall", longint'(o_flush_if), longint'(o_stall_ex));
      check("flush_id_tracks_stall", longint'(o_flush_id), longint'(o_stall_ex));
      if (prev_valid && o_redirect_valid)
        check("pc_stable", longint'(o_redirect_pc), longint'(prev_pc));
      prev_valid = o_redirect_valid;
      prev_pc    = o_redirect_pc;
      if (o_redirect_valid && i_fetch_ready) begin
        if (redir_q.size() == 0) begin
          check("unexpected_redirect", 1, 0);
        end else begin
          exp_pc = redir_q.pop_front();
          check("redirect_pc", longint'(o_redirect_pc), longint'(exp_pc));
        end
      end
      if (o_misaligned) begin
        if (mis_q.size() == 0) check("unexpected_misaligned", 1, 0);
        else void'(mis_q.pop_front());
      end
      while (req_q.size() > 0) begin
        r = req_q.pop_front();
        case (r.kind)
          K_MARK: begin
            cnt_stall = 0;
            cnt_valid = 0;
            cnt_mis   = 0;
          end
          K_VALID:   check(r.name, longint'(cnt_valid), r.exp);
          K_STALL:   check(r.name, longint'(cnt_stall), r.exp);
          K_MIS:     check(r.name, longint'(cnt_mis), r.exp);
          K_MIS_NOW: check(r.name, longint'(o_misaligned), r.exp);
          K_ZERO: begin
            check({r.name, "_valid"}, longint'(o_redirect_valid), 0);
            check({r.name, "_pc"}, longint'(o_redirect_pc), 0);
            check({r.name, "_flush_if"}, longint'(o_flush_if), 0);
            check({r.name, "_flush_id"}, longint'(o_flush_id), 0);
            check({r.name, "_stall"}, longint'(o_stall_ex), 0);
            check({r.name, "_mis"}, longint'(o_misaligned), 0);
          end
          K_BR: check(r.name, longint'(o_br_count), r.exp);
          K_TK: check(r.name, longint'(o_taken_count), r.exp);
          K_ST: check(r.name, longint'(o_stall_cycles), r.exp);
`ifdef BRANCH_REDIRECT_STATS_EN
          K_SAT: check(r.name, longint'(s_tk), r.exp);
`endif
          K_END: begin
            check("redirects_drained", longint'(redir_q.size()), 0);
            check("misaligned_drained", longint'(mis_q.size()), 0);
          end
          default: check("bad_request_kind", longint'(r.kind), -1);
        endcase
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic req(input int kind, input string name, input longint exp);
    req_t r;
    r.kind = kind;
    r.name = name;
    r.exp  = exp;
    req_q.push_back(r);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_ex_valid     = 1'b0;
    i_ex_is_branch = 1'b0;
    i_ex_is_jump   = 1'b0;
    i_branch_taken = 1'b0;
    i_target_pc    = '0;
  endtask

  // One-cycle EX resolution.
  task automatic issue(input logic br, input logic jmp, input logic tk, input logic [XLEN-1:0] tgt);
    i_ex_valid     = 1'b1;
    i_ex_is_branch = br;
    i_ex_is_jump   = jmp;
    i_branch_taken = tk;
    i_target_pc    = tgt;
    step();
    clear_inputs();
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    step();
    step();
    i_rst_n = 1'b1;
    step();
  endtask

  initial begin
    clear_inputs();
    i_fetch_ready = 1'b0;
    i_rst_n       = 1'b0;
    #1;
    req(K_ZERO, "reset", 0);
    req(K_BR, "reset_br_count", 0);
    req(K_TK, "reset_taken_count", 0);
    req(K_ST, "reset_stall_cycles", 0);
    step();
    step();
    i_rst_n = 1'b1;
    step();

    // Not-taken branch: nothing happens.
    req(K_MARK, "", 0);
    issue(1'b1, 1'b0, 1'b0, 32'h0000_0100);
    repeat (3) step();
    req(K_VALID, "nt_valid_cycles", 0);
    req(K_STALL, "nt_stall_cycles", 0);

    // Taken branch, fetch ready immediately.
    i_fetch_ready = 1'b1;
    req(K_MARK, "", 0);
    redir_q.push_back(32'h0000_0100);
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0100);
    repeat (5) step();
    req(K_VALID, "tk_valid_cycles", 1);
    req(K_STALL, "tk_stall_cycles", 3);

    // JAL with branch_taken=0, ready held low 4 cycles; a stray EX pulse must be ignored.
    i_fetch_ready = 1'b0;
    req(K_MARK, "", 0);
    redir_q.push_back(32'h0000_0200);
    issue(1'b0, 1'b1, 1'b0, 32'h0000_0200);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        i_ex_valid   = 1'b1;
        i_ex_is_jump = 1'b1;
        i_target_pc  = 32'h0000_0400;
      end
      step();
      clear_inputs();
    end
    i_fetch_ready = 1'b1;
    step();
    i_fetch_ready = 1'b0;
    repeat (4) step();
    req(K_VALID, "jal_valid_cycles", 5);
    req(K_STALL, "jal_stall_cycles", 7);

    // Branch and jump flags together behave as a jump.
    i_fetch_ready = 1'b1;
    req(K_MARK, "", 0);
    redir_q.push_back(32'h0000_0500);
    issue(1'b1, 1'b1, 1'b0, 32'h0000_0500);
    repeat (5) step();
    req(K_VALID, "brjmp_valid_cycles", 1);
    req(K_STALL, "brjmp_stall_cycles", 3);

    // Misaligned taken target: single-cycle pulse, no redirect.
    req(K_MARK, "", 0);
    mis_q.push_back(1);
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0102);
    req(K_MIS_NOW, "mis_pulse_high", 1);
    step();
    req(K_MIS_NOW, "mis_pulse_low", 0);
    repeat (3) step();
    req(K_VALID, "mis_valid_cycles", 0);
    req(K_STALL, "mis_stall_cycles", 0);
    req(K_MIS, "mis_pulse_cycles", 1);

    // Async reset while waiting in REDIRECT drops the redirect.
    i_fetch_ready = 1'b0;
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0280);
    step();
    #1;
    i_rst_n = 1'b0;
    req(K_ZERO, "async_reset", 0);
    @(negedge i_clk);
    step();
    i_rst_n = 1'b1;
    step();
    i_fetch_ready = 1'b1;
    req(K_MARK, "", 0);
    redir_q.push_back(32'h0000_0300);
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0300);
    repeat (5) step();
    req(K_VALID, "post_reset_valid_cycles", 1);
    req(K_STALL, "post_reset_stall_cycles", 3);

    // Statistics: three branches, two taken.
    do_reset();
    issue(1'b1, 1'b0, 1'b0, 32'h0000_0100);
    redir_q.push_back(32'h0000_0100);
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0100);
    repeat (5) step();
    redir_q.push_back(32'h0000_0140);
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0140);
    repeat (5) step();
`ifdef BRANCH_REDIRECT_STATS_EN
    req(K_BR, "stats_br_count", 3);
    req(K_TK, "stats_taken_count", 2);
    req(K_ST, "stats_stall_cycles", 6);
    // Back-to-back misaligned takes saturate a 4-bit counter.
    i_ex_valid     = 1'b1;
    i_ex_is_branch = 1'b1;
    i_branch_taken = 1'b1;
    i_target_pc    = 32'h0000_0102;
    for (int i = 0; i < 20; i++) begin
      mis_q.push_back(1);
      step();
    end
    clear_inputs();
    step();
    req(K_SAT, "stats_taken_saturated", 15);
`else
    req(K_BR, "tied_br_count", 0);
    req(K_TK, "tied_taken_count", 0);
    req(K_ST, "tied_stall_cycles", 0);
`endif

    step();
    req(K_END, "", 0);
    repeat (3) step();
    if (req_q.size() != 0) $display("FAIL monitor_stalled: got %0d pending requests, expected 0", req_q.size());
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
